// File: rtl/song_draw_ctrl.sv
// Control FSM for the note-highway datapath: clears the screen, then draws the 12 note
// boxes once per frame. Define STEP_MODE_EN to advance frames from the step input.
module song_draw_ctrl #(
  parameter int FRAME_TICKS = 12500000,
  parameter int SONG_LEN    = 112,
  parameter int BOX_LAT     = 3,
  parameter int DEF_LAT     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
`ifdef STEP_MODE_EN
  input  logic        step,
`endif
  output logic        shiftSong,
  output logic        writeToScreen,
  output logic        loadX,
  output logic        loadY,
  output logic        loadStartAddress,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        songDone,
  output logic [15:0] gridCounter,
  output logic [3:0]  boxCounter,
  output logic [14:0] pixelCount,
  output logic        plot,
  output logic        busy
);

  localparam int TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int SHIFT_W = $clog2(SONG_LEN + 1);
  localparam int LAT_MAX = (BOX_LAT > DEF_LAT) ? BOX_LAT : DEF_LAT;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [15:0] LAST_GRID = {8'd239, 8'd179};
  localparam logic [14:0] LAST_PIX  = {8'd59, 7'd59};

  typedef enum logic [2:0] {
    IDLE, CLEAR, DRAIN_D, WAIT, SHIFT, DRAW, DRAIN_B, DONE
  } stateT;

  stateT               state;
  logic [TICK_W-1:0]   tickCount;
  logic [LAT_W-1:0]    latCount;
  logic [SHIFT_W-1:0]  shiftCount;
  logic                drawValid;
  logic [DEF_LAT-1:0]  defPipe;
  logic [BOX_LAT-1:0]  boxPipe;
  logic                frameAdvance;

`ifdef STEP_MODE_EN
  assign frameAdvance = step;
`else
  assign frameAdvance = (tickCount == TICK_W'(FRAME_TICKS - 1));
`endif

  // Each path's valid bit runs through its own delay line so plot lines up with the
  // datapath latency of whichever path produced the pixel.
  assign plot = defPipe[DEF_LAT-1] | boxPipe[BOX_LAT-1];

  // NOTE: every register here, including the plot delay lines, is reset synchronously so
  // that no half-drawn pixel can leak onto plot after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      shiftSong        <= 1'b0;
      writeToScreen    <= 1'b0;
      loadX            <= 1'b0;
      loadY            <= 1'b0;
      loadStartAddress <= 1'b0;
      loadDefault      <= 1'b0;
      writeDefault     <= 1'b0;
      songDone         <= 1'b0;
      gridCounter      <= '0;
      boxCounter       <= '0;
      pixelCount       <= '0;
      tickCount        <= '0;
      latCount         <= '0;
      shiftCount       <= '0;
      drawValid        <= 1'b0;
      defPipe          <= '0;
      boxPipe          <= '0;
    end else begin
      shiftSong        <= 1'b0;
      songDone         <= 1'b0;
      loadStartAddress <= 1'b0;
      defPipe          <= (defPipe << 1) | DEF_LAT'(loadDefault);
      boxPipe          <= (boxPipe << 1) | BOX_LAT'(drawValid);

      case (state)
        IDLE: begin
          if (start) begin
            state        <= CLEAR;
            busy         <= 1'b1;
            loadDefault  <= 1'b1;
            writeDefault <= 1'b1;
            gridCounter  <= '0;
          end
        end

        CLEAR: begin
          if (gridCounter == LAST_GRID) begin
            state       <= DRAIN_D;
            loadDefault <= 1'b0;
            gridCounter <= '0;
            latCount    <= '0;
          end else if (gridCounter[7:0] == 8'd179) begin
            gridCounter <= {gridCounter[15:8] + 8'd1, 8'd0};
          end else begin
            gridCounter[7:0] <= gridCounter[7:0] + 8'd1;
          end
        end

        DRAIN_D: begin
          if (latCount == LAT_W'(DEF_LAT - 1)) begin
            state        <= WAIT;
            writeDefault <= 1'b0;
            tickCount    <= '0;
          end else begin
            latCount <= latCount + LAT_W'(1);
          end
        end

        WAIT: begin
          if (frameAdvance) begin
            state     <= SHIFT;
            shiftSong <= 1'b1;
          end else begin
            tickCount <= tickCount + TICK_W'(1);
          end
        end

        SHIFT: begin
          state            <= DRAW;
          shiftCount       <= shiftCount + SHIFT_W'(1);
          boxCounter       <= 4'd1;
          writeToScreen    <= 1'b1;
          loadX            <= 1'b1;
          loadY            <= 1'b1;
          loadStartAddress <= 1'b1;
          drawValid        <= 1'b1;
          pixelCount       <= '0;
        end

        DRAW: begin
          if (pixelCount == LAST_PIX) begin
            state     <= DRAIN_B;
            drawValid <= 1'b0;
            latCount  <= '0;
          end else if (pixelCount[6:0] == 7'd59) begin
            pixelCount <= {pixelCount[14:7] + 8'd1, 7'd0};
          end else begin
            pixelCount[6:0] <= pixelCount[6:0] + 7'd1;
          end
        end

        DRAIN_B: begin
          if (latCount == LAT_W'(BOX_LAT - 1)) begin
            pixelCount <= '0;
            if (boxCounter < 4'd12) begin
              state            <= DRAW;
              boxCounter       <= boxCounter + 4'd1;
              loadStartAddress <= 1'b1;
              drawValid        <= 1'b1;
            end else begin
              boxCounter    <= '0;
              writeToScreen <= 1'b0;
              loadX         <= 1'b0;
              loadY         <= 1'b0;
              if (shiftCount == SHIFT_W'(SONG_LEN)) begin
                state    <= DONE;
                songDone <= 1'b1;
              end else begin
                state     <= WAIT;
                tickCount <= '0;
              end
            end
          end else begin
            latCount <= latCount + LAT_W'(1);
          end
        end

        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          shiftCount <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_draw_ctrl.sv
// Bench for song_draw_ctrl: three instances run concurrently (full short song, frame
// repeat, reset mid-draw) against a timeline model derived from the state durations.
module tb_song_draw_ctrl;

  localparam int FRAME_TICKS = 20;
  localparam int BOX_LAT     = 3;
  localparam int DEF_LAT     = 2;
  localparam int NDUT        = 3;
  localparam int CLEAR_CYC   = 43200;
  localparam int BOX_PIX     = 3600;
  localparam int BOX_CYC     = BOX_PIX + BOX_LAT;
  localparam int NBOX        = 12;
  localparam int MAX_MISS    = 25;

  typedef struct packed {
    logic        shiftSong;
    logic        writeToScreen;
    logic        loadX;
    logic        loadY;
    logic        loadStartAddress;
    logic        loadDefault;
    logic        writeDefault;
    logic        songDone;
    logic [15:0] gridCounter;
    logic [3:0]  boxCounter;
    logic [14:0] pixelCount;
    logic        plot;
    logic        busy;
  } outsT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetIn [NDUT];
  logic startIn [NDUT];
`ifdef STEP_MODE_EN
  logic stepIn  [NDUT];
`endif
  outsT obs [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  // Instance 0 ends its song after one frame; instances 1 and 2 use a two-frame song.
  for (genvar g = 0; g < NDUT; g++) begin : gDut
    song_draw_ctrl #(
      .FRAME_TICKS(FRAME_TICKS),
      .SONG_LEN   ((g == 0) ? 1 : 2),
      .BOX_LAT    (BOX_LAT),
      .DEF_LAT    (DEF_LAT)
    ) dut (
      .clock           (clock),
      .reset           (resetIn[g]),
      .start           (startIn[g]),
`ifdef STEP_MODE_EN
      .step            (stepIn[g]),
`endif
      .shiftSong       (obs[g].shiftSong),
      .writeToScreen   (obs[g].writeToScreen),
      .loadX           (obs[g].loadX),
      .loadY           (obs[g].loadY),
      .loadStartAddress(obs[g].loadStartAddress),
      .loadDefault     (obs[g].loadDefault),
      .writeDefault    (obs[g].writeDefault),
      .songDone        (obs[g].songDone),
      .gridCounter     (obs[g].gridCounter),
      .boxCounter      (obs[g].boxCounter),
      .pixelCount      (obs[g].pixelCount),
      .plot            (obs[g].plot),
      .busy            (obs[g].busy)
    );
  end

  // ---------------- reference model: cycle t counts from the first CLEAR cycle ----------
  function automatic int frameLenOf(input int waitLen);
    return waitLen + 1 + NBOX * BOX_CYC;
  endfunction

  function automatic int songEndOf(input int waitLen, input int songLen);
    return CLEAR_CYC + DEF_LAT + songLen * frameLenOf(waitLen);
  endfunction

  function automatic int frameOffset(input int t, input int waitLen, input int songLen);
    if (t < CLEAR_CYC + DEF_LAT || t >= songEndOf(waitLen, songLen)) return -1;
    return (t - CLEAR_CYC - DEF_LAT) % frameLenOf(waitLen);
  endfunction

  function automatic bit defValid(input int t);
    return (t >= 0) && (t < CLEAR_CYC);
  endfunction

  function automatic bit boxValid(input int t, input int waitLen, input int songLen);
    int r;
    r = frameOffset(t, waitLen, songLen);
    if (r <= waitLen) return 1'b0;
    return ((r - waitLen - 1) % BOX_CYC) < BOX_PIX;
  endfunction

  function automatic outsT expectedAt(input int t, input int waitLen, input int songLen);
    outsT e;
    int songEnd, r, q, p;
    e = '0;
    songEnd = songEndOf(waitLen, songLen);
    if (t < 0 || t > songEnd) return e;
    e.busy = 1'b1;
    r = frameOffset(t, waitLen, songLen);
    if (t < CLEAR_CYC) begin
      e.loadDefault  = 1'b1;
      e.writeDefault = 1'b1;
      e.gridCounter  = {8'(t / 180), 8'(t % 180)};
    end else if (t < CLEAR_CYC + DEF_LAT) begin
      e.writeDefault = 1'b1;
    end else if (t == songEnd) begin
      e.songDone = 1'b1;
    end else if (r == waitLen) begin
      e.shiftSong = 1'b1;
    end else if (r > waitLen) begin
      q = r - waitLen - 1;
      p = q % BOX_CYC;
      e.boxCounter    = 4'(q / BOX_CYC + 1);
      e.writeToScreen = 1'b1;
      e.loadX         = 1'b1;
      e.loadY         = 1'b1;
      if (p < BOX_PIX) begin
        e.pixelCount       = {8'(p / 60), 7'(p % 60)};
        e.loadStartAddress = (p == 0);
      end else begin
        e.pixelCount = {8'd59, 7'd59};
      end
    end
    e.plot = defValid(t - DEF_LAT) || boxValid(t - BOX_LAT, waitLen, songLen);
    return e;
  endfunction

  function automatic int pickWaitLen();
`ifdef STEP_MODE_EN
    return 101 + int'($urandom_range(0, 8));
`else
    return FRAME_TICKS;
`endif
  endfunction

  task automatic stop_if_flooded();
    if (miscompares >= MAX_MISS) begin
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  endtask

  // Starts instance idx and checks every cycle t = 0..tEnd; start is randomised while it
  // must be ignored and step is pulsed once per WAIT after being held low.
  task automatic run_timeline(input int idx, input int songLen, input int waitLen,
                              input int tEnd, input bit holdStartAtEnd, input string name);
    outsT exp, got;
    int songEnd, r;
    songEnd = songEndOf(waitLen, songLen);
    @(negedge clock);
    startIn[idx] = 1'b1;
    for (int t = 0; t <= tEnd; t++) begin
      @(negedge clock);
      exp = expectedAt(t, waitLen, songLen);
      got = obs[idx];
      if (!defValid(t)) got.gridCounter = '0;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s dut%0d t=%0d got=%h expected=%h", name, idx, t, got, exp);
        stop_if_flooded();
      end
      if (holdStartAtEnd && t >= songEnd - 3) startIn[idx] = 1'b1;
      else if (t >= songEnd) startIn[idx] = 1'b0;
      else startIn[idx] = 1'($urandom_range(0, 1));
      r = frameOffset(t, waitLen, songLen);
`ifdef STEP_MODE_EN
      if (r >= 0 && r < waitLen) stepIn[idx] = (r == waitLen - 1);
      else stepIn[idx] = ($urandom_range(0, 63) == 0);
`else
      if (r == -2) startIn[idx] = 1'b0;
`endif
    end
  endtask

  // ---------------- scenarios -----------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < NDUT; i++) begin
      resetIn[i] = 1'b0;
      startIn[i] = 1'($urandom_range(0, 1));
`ifdef STEP_MODE_EN
      stepIn[i] = 1'b0;
`endif
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < NDUT; i++) begin
      vectors++;
      if (obs[i] !== '0) begin
        miscompares++;
        $display("FAIL reset dut%0d got=%h expected=0", i, obs[i]);
      end
      resetIn[i] = 1'b1;
      startIn[i] = 1'b0;
    end
    @(negedge clock);
    for (int i = 0; i < NDUT; i++) begin
      vectors++;
      if (obs[i] !== '0) begin
        miscompares++;
        $display("FAIL idle_after_reset dut%0d got=%h expected=0", i, obs[i]);
      end
    end
  endtask

  task automatic test_full_song();
    int w, songEnd;
    outsT exp;
    w = pickWaitLen();
    songEnd = songEndOf(w, 1);
    run_timeline(0, 1, w, songEnd + 1, 1'b1, "song");
    // start held through DONE: IDLE lasts one cycle, then a fresh CLEAR begins
    @(negedge clock);
    exp = expectedAt(0, w, 1);
    vectors++;
    if (obs[0] !== exp) begin
      miscompares++;
      $display("FAIL restart dut0 got=%h expected=%h", obs[0], exp);
    end
    startIn[0] = 1'b0;
    resetIn[0] = 1'b0;
    @(negedge clock);
    resetIn[0] = 1'b1;
  endtask

  task automatic test_frame_repeat();
    int w, tEnd;
    w = pickWaitLen();
    // through frame 1, back through WAIT and SHIFT, 50 pixels into frame 2
    tEnd = CLEAR_CYC + DEF_LAT + frameLenOf(w) + w + 1 + 50;
    run_timeline(1, 2, w, tEnd, 1'b0, "frame_repeat");
    startIn[1] = 1'b0;
    resetIn[1] = 1'b0;
    @(negedge clock);
    resetIn[1] = 1'b1;
  endtask

  task automatic test_reset_mid_draw();
    int w, tStop;
    w = pickWaitLen();
    tStop = CLEAR_CYC + DEF_LAT + w + 1 + 6 * BOX_CYC + 1000;  // box 7, pixel 1000
    run_timeline(2, 2, w, tStop, 1'b0, "mid_draw");
    resetIn[2] = 1'b0;
    startIn[2] = 1'b0;
`ifdef STEP_MODE_EN
    stepIn[2] = 1'b0;
`endif
    @(negedge clock);
    vectors++;
    if (obs[2] !== '0) begin
      miscompares++;
      $display("FAIL mid_draw_reset dut2 got=%h expected=0", obs[2]);
    end
    resetIn[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      vectors++;
      if (obs[2] !== '0) begin
        miscompares++;
        $display("FAIL post_reset_quiet dut2 cycle=%0d got=%h expected=0", k, obs[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    fork
      test_full_song();
      test_frame_repeat();
      test_reset_mid_draw();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(10 * 120000);
    miscompares++;
    $display("FAIL watchdog got=still_running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
